// File: rtl/fht_frame_seq.sv
// Frame sequencer: loads N=4*2^A_BIT samples into four banks, starts the FHT core, unloads in natural order.
// Load writes 1 cycle after accept, valid RD_LAT after read, no output backpressure; FHT_BITREV_LOAD_EN bit-reverses load order.
module fht_frame_seq #(
  parameter int A_BIT  = 9,
  parameter int D_BIT  = 16,
  parameter int RD_LAT = 2
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iVALID_IN,
  input  logic [D_BIT-1:0] iDATA_IN,
  output logic             oREADY_IN,
  output logic             oWE_LOAD,
  output logic [1:0]       oBANK_LOAD,
  output logic [A_BIT-1:0] oADDR_LOAD,
  output logic [D_BIT-1:0] oDATA_LOAD,
  output logic             oSTART_FHT,
  input  logic             iRDY_FHT,
  output logic             oMEM_OWN,
  output logic             oRD_UNLOAD,
  output logic [1:0]       oBANK_UNLOAD,
  output logic [A_BIT-1:0] oADDR_UNLOAD,
  output logic             oVALID_OUT,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR
);

  localparam int I_BIT = A_BIT + 2;
  localparam logic [I_BIT-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_RUN, S_UNLOAD, S_FLUSH
  } state_t;

  state_t            r_state;
  logic [I_BIT-1:0]  r_idx;
  logic [1:0]        r_tcnt;
  logic [2:0]        r_fcnt;
  logic [RD_LAT-1:0] r_vpipe;
  logic              r_ready, r_we, r_start, r_own, r_rd, r_busy, r_done, r_err;
  logic [1:0]        r_bank_ld, r_bank_ul;
  logic [A_BIT-1:0]  r_addr_ld, r_addr_ul;
  logic [D_BIT-1:0]  r_data_ld;

  logic              w_accept;
  logic              w_ul_last;
  logic [I_BIT-1:0]  w_ld_pos;

  assign w_accept  = iVALID_IN & r_ready;
  assign w_ul_last = &{r_addr_ul, r_bank_ul};

`ifdef FHT_BITREV_LOAD_EN
  always_comb begin
    w_ld_pos = '0;
    for (int i = 0; i < I_BIT; i++) w_ld_pos[i] = r_idx[I_BIT-1-i];
  end
`else
  assign w_ld_pos = r_idx;
`endif

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_tcnt    <= '0;
      r_fcnt    <= '0;
      r_vpipe   <= '0;
      r_ready   <= 1'b1;
      r_we      <= 1'b0;
      r_start   <= 1'b0;
      r_own     <= 1'b0;
      r_rd      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_bank_ld <= '0;
      r_addr_ld <= '0;
      r_data_ld <= '0;
      r_bank_ul <= '0;
      r_addr_ul <= '0;
    end else begin
      r_we    <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;

      r_vpipe[0] <= r_rd;
      for (int i = 1; i < RD_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];

      if (w_accept) begin
        r_we      <= 1'b1;
        r_bank_ld <= w_ld_pos[1:0];
        r_addr_ld <= w_ld_pos[I_BIT-1:2];
        r_data_ld <= iDATA_IN;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= r_idx + 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_ready <= 1'b0;
              r_start <= 1'b1;
              r_own   <= 1'b1;
              r_state <= S_START;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_START: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT_ACK;
        end
        // Core must drop ready within four cycles of the start pulse.
        S_WAIT_ACK: begin
          if (!iRDY_FHT) begin
            r_state <= S_RUN;
          end else if (r_tcnt == 2'd3) begin
            r_err   <= 1'b1;
            r_own   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_RUN: begin
          if (iRDY_FHT) begin
            r_own     <= 1'b0;
            r_rd      <= 1'b1;
            r_bank_ul <= '0;
            r_addr_ul <= '0;
            r_idx     <= {{(I_BIT-1){1'b0}}, 1'b1};
            r_state   <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (w_ul_last) begin
            r_rd    <= 1'b0;
            r_fcnt  <= '0;
            r_idx   <= '0;
            r_state <= S_FLUSH;
          end else begin
            r_bank_ul <= r_idx[1:0];
            r_addr_ul <= r_idx[I_BIT-1:2];
            r_idx     <= r_idx + 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == 3'(RD_LAT - 1)) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_own   <= 1'b0;
          r_rd    <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oREADY_IN    = r_ready;
  assign oWE_LOAD     = r_we;
  assign oBANK_LOAD   = r_bank_ld;
  assign oADDR_LOAD   = r_addr_ld;
  assign oDATA_LOAD   = r_data_ld;
  assign oSTART_FHT   = r_start;
  assign oMEM_OWN     = r_own;
  assign oRD_UNLOAD   = r_rd;
  assign oBANK_UNLOAD = r_bank_ul;
  assign oADDR_UNLOAD = r_addr_ul;
  assign oVALID_OUT   = r_vpipe[RD_LAT-1];
  assign oBUSY        = r_busy;
  assign oDONE        = r_done;
  assign oERR         = r_err;

endmodule
